if_fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I 5-stage pipeline. Owns the PC register and issues one outstanding request at a time to a variable-latency instruction memory. Drives the IF/ID pipeline register consumed by the `Decoder`. Accepts stall from hazard detection and taken-branch/jump redirects from EX, which also flush IF/ID.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 14 +
 rtl/if_skid_buf.sv | 33 +++
 rtl/if_fetch_stage.sv | 117 +++++++++++
 tb/tb_if_fetch_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// canonical NOP and the default reset PC.
package if_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DROP,
        ST_FAULT
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pc_plus_4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr,
                    input  imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input  imem_req, imem_addr,
                    output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry instruction/PC holding buffer. Clear beats load beats unload.
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID register.
// Optional misaligned-redirect fault enabled by defining IF_ALIGN_CHECK_EN.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    if_fetch_stage_if.master imem,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_instr,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc_plus_4,
    output logic             fetch_misaligned
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc, fetch_pc, tgt_pc, skid_instr, skid_pc;
    logic            skid_valid, to_ifid, skid_load, skid_unload, outstanding;

`ifdef IF_ALIGN_CHECK_EN
    logic misalign;
    assign tgt_pc   = redirect_pc;
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign tgt_pc           = redirect_pc & ~XLEN'(3);
    assign fetch_misaligned = 1'b0;
`endif

    assign imem.imem_req  = (state == ST_FETCH) && !reset;
    assign imem.imem_addr = pc;

    // A response goes straight to IF/ID unless ID is stalled on a real instruction.
    assign to_ifid     = (state == ST_WAIT) && imem.imem_rvalid && (!stall || !if_id_valid);
    assign skid_load   = !redirect && (state == ST_WAIT) && imem.imem_rvalid && !to_ifid;
    assign skid_unload = !redirect && (state == ST_HOLD) && !stall;
    assign outstanding = ((state == ST_WAIT || state == ST_DROP) && !imem.imem_rvalid) ||
                         ((state == ST_FETCH) && imem.imem_ready);

    if_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (redirect),
        .load_instr (imem.imem_rdata),
        .load_pc    (fetch_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_FETCH;
            pc              <= RESET_PC;
            fetch_pc        <= RESET_PC;
            if_id_valid     <= 1'b0;
            if_id_instr     <= NOP_INSTR;
            if_id_pc        <= '0;
            if_id_pc_plus_4 <= XLEN'(4);
`ifdef IF_ALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            // Bubble by default; loads below override.
            if (!stall) if_id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            if (misalign || state == ST_FAULT) begin
                state            <= ST_FAULT;
                if_id_valid      <= 1'b0;
                fetch_misaligned <= 1'b1;
            end else
`endif
            if (redirect) begin
                pc          <= tgt_pc;
                if_id_valid <= 1'b0;
                state       <= outstanding ? ST_DROP : ST_FETCH;
            end else begin
                case (state)
                    ST_FETCH: if (imem.imem_ready) begin
                        fetch_pc <= pc;
                        state    <= ST_WAIT;
                    end
                    ST_WAIT: if (imem.imem_rvalid) begin
                        if (to_ifid) begin
                            if_id_valid     <= 1'b1;
                            if_id_instr     <= imem.imem_rdata;
                            if_id_pc        <= fetch_pc;
                            if_id_pc_plus_4 <= pc_plus_4(fetch_pc);
                            pc              <= pc_plus_4(fetch_pc);
                            state           <= ST_FETCH;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: if (!stall && skid_valid) begin
                        if_id_valid     <= 1'b1;
                        if_id_instr     <= skid_instr;
                        if_id_pc        <= skid_pc;
                        if_id_pc_plus_4 <= pc_plus_4(skid_pc);
                        pc              <= pc_plus_4(skid_pc);
                        state           <= ST_FETCH;
                    end
                    ST_DROP: if (imem.imem_rvalid) state <= ST_FETCH;
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: transaction-level reference model,
// variable-latency memory model and directed scenarios with literal expectations.
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef IF_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid, fetch_misaligned;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus_4;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RPC), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem             (bus),
        .if_id_valid      (if_id_valid),
        .if_id_instr      (if_id_instr),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus_4  (if_id_pc_plus_4),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory model: one request at a time, lat extra cycles before rvalid.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0, lat = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < 0 || i >= acc_log.size()) return 32'hxxxx_xxxx;
        return acc_log[i];
    endfunction

    // Reference model: fetch address, outstanding/dropped request, held entries, IF/ID.
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_held[$];
    logic        m_v = 1'b0, m_out = 1'b0, m_drop = 1'b0, m_fault = 1'b0;
    logic [31:0] m_instr = NOP_INSTR, m_pc = '0, m_pc4 = 32'd4, m_next = RPC, m_faddr = '0;

    function automatic logic model_req();
        return !reset && !m_out && (m_held.size() == 0) && !m_fault;
    endfunction

    task automatic m_load(input logic [31:0] ins, input logic [31:0] p);
        m_v = 1'b1; m_instr = ins; m_pc = p; m_pc4 = p + 32'd4; m_next = p + 32'd4;
    endtask

    // Stimulus for the next cycle
    logic        n_reset = 1'b1, n_stall = 1'b0, n_redirect = 1'b0, n_ready = 1'b1;
    logic [31:0] n_rpc = '0;

    task automatic cyc();
        logic rv, mreq, macc, dacc, resp, got;
        logic [31:0] rd, daddr;
        ent_t e;
        #1;
        reset = n_reset; stall = n_stall; redirect = n_redirect; redirect_pc = n_rpc;
        rv = mem_busy && (mem_cnt == 0);
        rd = mem_word(mem_addr);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? rd : $urandom;
        bus.imem_ready  = n_ready && !mem_busy;
        #1;
        mreq  = model_req();
        macc  = mreq && bus.imem_ready;
        dacc  = bus.imem_req && bus.imem_ready;
        daddr = bus.imem_addr;
        @(posedge clk);
        if (reset) begin
            m_v = 1'b0; m_instr = NOP_INSTR; m_pc = '0; m_pc4 = 32'd4;
            m_out = 1'b0; m_drop = 1'b0; m_fault = 1'b0; m_next = RPC;
            m_held.delete();
            mem_busy = 1'b0;
        end else begin
            resp = m_out && rv;
            if (m_fault) begin
                m_v = 1'b0;
            end else if (redirect) begin
                m_v = 1'b0;
                m_held.delete();
                if (ALIGN && redirect_pc[1:0] != 2'b00) begin
                    m_fault = 1'b1;
                end else begin
                    m_next = {redirect_pc[31:2], 2'b00};
                    m_drop = (m_out && !resp) || macc;
                    m_out  = m_drop;
                end
            end else begin
                got = 1'b0;
                if (resp) begin
                    if (!m_drop) begin
                        if (!stall || !m_v) begin
                            m_load(rd, m_faddr);
                            got = 1'b1;
                        end else begin
                            e.instr = rd; e.pc = m_faddr;
                            m_held.push_back(e);
                        end
                    end
                    m_out = 1'b0; m_drop = 1'b0;
                end else if (m_held.size() != 0 && !stall) begin
                    e = m_held.pop_front();
                    m_load(e.instr, e.pc);
                    got = 1'b1;
                end
                if (!got && !stall) m_v = 1'b0;
                if (macc) begin m_out = 1'b1; m_drop = 1'b0; m_faddr = m_next; end
            end
            if (rv) mem_busy = 1'b0;
            else if (mem_busy && mem_cnt > 0) mem_cnt--;
            if (dacc) begin
                mem_busy = 1'b1; mem_cnt = lat; mem_addr = daddr;
                acc_log.push_back(daddr);
            end
        end
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, model_req()});
        if (model_req()) chk("imem_addr", bus.imem_addr, m_next);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_pc);
        chk("if_id_pc_plus_4", if_id_pc_plus_4, m_pc4);
        chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, m_fault});
    end

    logic [5:0] vh;

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        // Reset values
        n_reset = 1'b1; cyc(); cyc();
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0000_0013);
        chk("rst_pc4", if_id_pc_plus_4, 32'd4);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);

        // Latency-1 memory: requests 0x100/0x104/0x108, IF/ID valid every 2 cycles
        n_reset = 1'b0; n_ready = 1'b1; lat = 0; vh = '0;
        for (int i = 0; i < 6; i++) begin cyc(); vh = {vh[4:0], if_id_valid}; end
        chk("req0", log_at(0), 32'h0000_0100);
        chk("req1", log_at(1), 32'h0000_0104);
        chk("req2", log_at(2), 32'h0000_0108);
        chk("valid_pattern", {26'b0, vh}, 32'b010101);
        chk("c6_pc", if_id_pc, 32'h0000_0108);
        chk("c6_instr", if_id_instr, mem_word(32'h0000_0108));

        // Stall 3 cycles across a response: IF/ID frozen, skid released after
        n_stall = 1'b1; cyc(); cyc(); cyc();
        chk("stall_pc", if_id_pc, 32'h0000_0108);
        chk("stall_valid", {31'b0, if_id_valid}, 32'd1);
        chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
        n_stall = 1'b0; cyc();
        chk("unskid_pc", if_id_pc, 32'h0000_010C);
        chk("unskid_instr", if_id_instr, mem_word(32'h0000_010C));
        chk("resume_addr", bus.imem_addr, 32'h0000_0110);

        // Redirect while waiting; late response dropped
        lat = 2; cyc();
        n_redirect = 1'b1; n_rpc = 32'h0000_0200; cyc();
        n_redirect = 1'b0;
        chk("redir_valid", {31'b0, if_id_valid}, 32'd0);
        chk("redir_req", {31'b0, bus.imem_req}, 32'd0);
        cyc(); cyc();
        chk("drop_req", {31'b0, bus.imem_req}, 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h0000_0200);
        chk("drop_valid", {31'b0, if_id_valid}, 32'd0);

        // Redirect and stall together while holding; then PC wrap
        lat = 0; cyc(); cyc();
        chk("tgt_pc", if_id_pc, 32'h0000_0200);
        n_stall = 1'b1; cyc(); cyc();
        n_redirect = 1'b1; n_rpc = 32'hFFFF_FFFC; cyc();
        chk("flush_valid", {31'b0, if_id_valid}, 32'd0);
        chk("flush_addr", bus.imem_addr, 32'hFFFF_FFFC);
        n_redirect = 1'b0; n_stall = 1'b0; cyc();
        chk("flush_skid", {31'b0, if_id_valid}, 32'd0);
        cyc();
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc_plus_4, 32'h0000_0000);
        cyc();
        chk("wrap_req", log_at(acc_log.size() - 1), 32'h0000_0000);

`ifdef IF_ALIGN_CHECK_EN
        n_reset = 1'b1; cyc();
        n_reset = 1'b0; cyc();
        n_redirect = 1'b1; n_rpc = 32'h0000_0202; cyc();
        n_redirect = 1'b0;
        chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
        cyc(); cyc(); cyc();
        chk("mis_req", {31'b0, bus.imem_req}, 32'd0);
        chk("mis_sticky", {31'b0, fetch_misaligned}, 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            n_reset    = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 19) == 0);
            n_stall    = ($urandom_range(0, 9) < 3);
            n_redirect = ($urandom_range(0, 19) == 0);
            n_rpc      = $urandom;
            if ($urandom_range(0, 7) != 0) n_rpc[1:0] = 2'b00;
            n_ready    = ($urandom_range(0, 9) < 6);
            lat        = $urandom_range(0, 3);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
